// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push-port arbiter.
package fifo_arb_pkg;

    // Arbiter FSM: IDLE picks the next owner, GRANT streams that owner's beats.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Upper bound on requesters the generic picker can handle.
    localparam int unsigned RR_MAX_REQ = 32;
    localparam int unsigned RR_IDX_W   = 5;

    // Round-robin select: first set bit of valid at or after ptr, wrapping
    // modulo n. Returns 0 when nothing is valid (caller checks any-valid).
    function automatic int unsigned rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input int unsigned           ptr,
        input int unsigned           n
    );
        int unsigned pick;
        int unsigned idx;
        logic        found;
        pick  = 32'd0;
        idx   = 32'd0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
            if ((k < n) && !found) begin
                idx = (ptr + k) % n;
                if (valid[idx[RR_IDX_W-1:0]]) begin
                    found = 1'b1;
                    pick  = idx;
                end else begin
                    found = 1'b0;
                end
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_chk.sv
// Simulation checker: the tracked FIFO level must never overflow or underflow.
module fifo_push_arbiter_chk #(
    parameter  int DEPTH = 16,
    localparam int LVW   = $clog2(DEPTH+1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [LVW-1:0] level,
    input  logic           push,
    input  logic           pop_eff
);

    // Flag a push into a full level or a pop from an empty level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!((level == LVW'(DEPTH)) && push && !pop_eff))
                else $error("fifo_push_arbiter: level overflow");
            assert (!((level == LVW'(0)) && pop_eff && !push))
                else $error("fifo_push_arbiter: level underflow");
        end
    end

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin priority select over NUM_REQ request lines.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     pick,
    output logic               any_valid
);

    logic [RR_MAX_REQ-1:0] valid_ext_s;

    // Widen the request vector to the helper's width and select the winner.
    always_comb begin
        valid_ext_s                = '0;
        valid_ext_s[NUM_REQ-1:0]   = valid;
        pick                       = IDW'(rr_pick(valid_ext_s, 32'(ptr), NUM_REQ));
        any_valid                  = |valid;
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one FIFO push port among NUM_REQ producers with round-robin,
// burst-locked grants, and tracks FIFO occupancy from observed push/pop.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    parameter  int NUM_REQ    = 4,
    parameter  int BURST_LEN  = 4,
    localparam int IDW        = $clog2(NUM_REQ),
    localparam int LVW        = $clog2(DEPTH+1),
    localparam int BCW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_push,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_pop,
    input  logic                          fifo_empty,
    output logic                          grant_valid,
    output logic [IDW-1:0]                grant_id,
    output logic [LVW-1:0]                level
);

    arb_state_e      state_q,    state_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LVW-1:0]  level_q,    level_d;

    logic [IDW-1:0]  pick_s;
    logic            any_valid_s;
    logic            xfer_s;
    logic            last_beat_s;
    logic            pop_eff_s;
    logic [IDW-1:0]  next_ptr_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .valid     (req_valid),
        .ptr       (rr_ptr_q),
        .pick      (pick_s),
        .any_valid (any_valid_s)
    );

    // Transfer qualification and push-side datapath; reset suppresses any push.
    always_comb begin
        xfer_s = 1'b0;
        if ((state_q == GRANT) && !rst) begin
            xfer_s = req_valid[grant_id_q] & ~fifo_full;
        end else begin
            xfer_s = 1'b0;
        end
        fifo_push    = xfer_s;
        fifo_data_in = '0;
        req_ready    = '0;
        if (xfer_s) begin
            fifo_data_in = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
            req_ready    = NUM_REQ'(1) << grant_id_q;
        end else begin
            fifo_data_in = '0;
            req_ready    = '0;
        end
        last_beat_s = (beat_cnt_q == BCW'(BURST_LEN-1));
        pop_eff_s   = fifo_pop & ~fifo_empty;
        if (grant_id_q == IDW'(NUM_REQ-1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_id_q + IDW'(1);
        end
    end

    // Next-state logic: pick an owner in IDLE, count beats and release in GRANT.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid_s) begin
                    state_d    = GRANT;
                    grant_id_d = pick_s;
                    beat_cnt_d = '0;
                end else begin
                    state_d    = IDLE;
                end
            end
            GRANT: begin
                if (!req_valid[grant_id_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr_s;
                end else if (xfer_s && last_beat_s) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr_s;
                end else if (xfer_s) begin
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Occupancy tracking: push adds, effective pop subtracts, both cancel.
    always_comb begin
        level_d = level_q;
        case ({xfer_s, pop_eff_s})
            2'b10:   level_d = level_q + LVW'(1);
            2'b01:   level_d = level_q - LVW'(1);
            default: level_d = level_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            level_q    <= level_d;
        end
    end

    // Status outputs come straight from registered state.
    always_comb begin
        grant_valid = (state_q == GRANT);
        grant_id    = grant_id_q;
        level       = level_q;
    end

    fifo_push_arbiter_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .level   (level_q),
        .push    (xfer_s),
        .pop_eff (pop_eff_s)
    );

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed self-checking bench for fifo_push_arbiter.
module tb_fifo_push_arbiter;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int NR    = 4;
    localparam int BL    = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]  req_ready;
    logic           fifo_push;
    logic [DW-1:0]  fifo_data_in;
    logic           fifo_full;
    logic           fifo_pop;
    logic           fifo_empty;
    logic           grant_valid;
    logic [1:0]     grant_id;
    logic [4:0]     level;

    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_level = 0;
    logic force_full = 1'b0;
    logic [3:0] seq [NR];

    always #5 clk = ~clk;

    fifo_push_arbiter #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .NUM_REQ    (NR),
        .BURST_LEN  (BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_push    (fifo_push),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .fifo_pop     (fifo_pop),
        .fifo_empty   (fifo_empty),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .level        (level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] word(input int i);
        return {4'(i), seq[i]};
    endfunction

    task automatic set_data();
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word(i);
    endtask

    task automatic apply_flags();
        fifo_full  = force_full | (exp_level >= DEPTH);
        fifo_empty = (exp_level == 0);
    endtask

    // Advance one clock, updating the occupancy model from the expected push.
    task automatic step(input logic e_push);
        if (rst) exp_level = 0;
        else exp_level = exp_level + (e_push ? 1 : 0) - ((fifo_pop && !fifo_empty) ? 1 : 0);
        @(posedge clk);
        #1;
        apply_flags();
    endtask

    task automatic cyc(input string tag, input logic e_gv, input int e_gid,
                       input logic e_push, input logic [3:0] e_ready, input logic [7:0] e_data);
        #1;
        chk({tag, ".gv"},    {31'd0, grant_valid}, {31'd0, e_gv});
        chk({tag, ".gid"},   {30'd0, grant_id},    e_gid);
        chk({tag, ".push"},  {31'd0, fifo_push},   {31'd0, e_push});
        chk({tag, ".ready"}, {28'd0, req_ready},   {28'd0, e_ready});
        if (e_push) chk({tag, ".data"}, {24'd0, fifo_data_in}, {24'd0, e_data});
        chk({tag, ".level"}, {27'd0, level}, exp_level);
        step(e_push);
    endtask

    task automatic beat(input string tag, input int g);
        cyc(tag, 1'b1, g, 1'b1, 4'(4'b0001 << g), word(g));
        seq[g] = seq[g] + 4'd1;
        set_data();
    endtask

    task automatic idle(input string tag, input int gid);
        cyc(tag, 1'b0, gid, 1'b0, 4'b0000, 8'h00);
    endtask

    task automatic stall(input string tag, input int g);
        cyc(tag, 1'b1, g, 1'b0, 4'b0000, 8'h00);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 4'b0000;
        fifo_pop   = 1'b0;
        force_full = 1'b0;
        step(1'b0);
        step(1'b0);
        #1;
        chk("rst.gv",    {31'd0, grant_valid}, 32'd0);
        chk("rst.gid",   {30'd0, grant_id},    32'd0);
        chk("rst.push",  {31'd0, fifo_push},   32'd0);
        chk("rst.ready", {28'd0, req_ready},   32'd0);
        chk("rst.level", {27'd0, level},       32'd0);
        rst = 1'b0;
    endtask

    initial begin
        int prev;
        rst       = 1'b1;
        req_valid = 4'b0000;
        fifo_pop  = 1'b0;
        for (int i = 0; i < NR; i++) seq[i] = 4'd0;
        set_data();
        apply_flags();

        // 1: single producer, burst of 4, one gap cycle, re-grant of id 0
        do_reset();
        req_valid = 4'b0001;
        idle("t1_idle", 0);
        for (int b = 0; b < BL; b++) beat("t1_beat", 0);
        idle("t1_gap", 0);
        beat("t1_regrant", 0);
        req_valid = 4'b0000;
        stall("t1_drop", 0);
        idle("t1_end", 0);

        // 2: all producers steady, order 0,1,2,3,0 with 4 pushes each
        do_reset();
        req_valid = 4'b1111;
        fifo_pop  = 1'b1;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            idle("t2_gap", prev);
            for (int b = 0; b < BL; b++) beat("t2_beat", k % NR);
            prev = k % NR;
        end
        fifo_pop  = 1'b0;
        req_valid = 4'b0000;
        idle("t2_end", 0);

        // 3: full stall of 3 cycles mid-burst on id 2
        do_reset();
        req_valid = 4'b0100;
        idle("t3_idle", 0);
        beat("t3_beat", 2);
        beat("t3_beat", 2);
        force_full = 1'b1;
        apply_flags();
        for (int s = 0; s < 3; s++) stall("t3_full", 2);
        force_full = 1'b0;
        apply_flags();
        beat("t3_resume", 2);
        beat("t3_resume", 2);
        req_valid = 4'b0000;
        idle("t3_end", 2);

        // 4: owner drops after 2 beats, next pick starts at owner+1
        do_reset();
        req_valid = 4'b0010;
        idle("t4_idle", 0);
        beat("t4_beat", 1);
        beat("t4_beat", 1);
        req_valid = 4'b1001;
        stall("t4_drop", 1);
        idle("t4_gap", 1);
        beat("t4_next", 3);
        req_valid = 4'b0000;
        stall("t4_stop", 3);
        idle("t4_end", 3);

        // 5: fill to 16, hold at full, drain with simultaneous push+pop at 8
        do_reset();
        req_valid = 4'b1111;
        prev = 0;
        for (int g = 0; g < NR; g++) begin
            idle("t5_gap", prev);
            for (int b = 0; b < BL; b++) beat("t5_fill", g);
            prev = g;
        end
        req_valid = 4'b0001;
        idle("t5_full_idle", 3);
        stall("t5_full_stall", 0);
        req_valid = 4'b0000;
        stall("t5_release", 0);
        fifo_pop = 1'b1;
        for (int p = 0; p < 7; p++) idle("t5_pop", 0);
        req_valid = 4'b0001;
        idle("t5_pop_idle", 0);
        for (int b = 0; b < BL; b++) beat("t5_pushpop", 0);
        req_valid = 4'b0000;
        for (int p = 0; p < 8; p++) idle("t5_drain", 0);
        idle("t5_empty_pop", 0);
        fifo_pop = 1'b0;
        idle("t5_done", 0);

        // 6: reset at beat 2 abandons the grant and clears the pointer
        do_reset();
        req_valid = 4'b0100;
        idle("t6_idle", 0);
        beat("t6_beat", 2);
        beat("t6_beat", 2);
        rst = 1'b1;
        stall("t6_rst", 2);
        rst = 1'b0;
        req_valid = 4'b1111;
        idle("t6_after", 0);
        beat("t6_regrant", 0);
        req_valid = 4'b0000;
        stall("t6_stop", 0);
        idle("t6_end", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
